gpio_input_port: RTL and testbench

Memory-mapped input port, the CPU-read counterpart of the GPIO output registers. Samples Width external input pins and synchronises them into the CLK domain. Debounces the samples and records any-edge events in sticky flags. Returns pin state, edge flags or the interrupt mask on DataInputTowardMicro when the CPU drives a matching AddressIO, and raises Irq for unmasked edges. Sits beside the output GPIO instances in the top level and shares the CPU's AddressIO, DataOutputTowardIO and WritePPI bus.

---
 rtl/gpio_pkg.sv | 11 +
 rtl/gpio_input_port_if.sv | 22 ++
 rtl/gpio_debounce_bit.sv | 41 ++++
 rtl/gpio_input_port.sv | 90 +++++++++
 tb/tb_gpio_input_port.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input port: bus widths and default register addresses.
package gpio_pkg;

   localparam int AddrW = 9;
   localparam int DataW = 32;

   localparam logic [AddrW-1:0] DefAddrData = 9'd30;
   localparam logic [AddrW-1:0] DefAddrEdge = 9'd31;
   localparam logic [AddrW-1:0] DefAddrMask = 9'd32;

endpackage

// File: rtl/gpio_input_port_if.sv
// CPU I/O bus seen by the GPIO input port: address, write data/strobe, registered read data and hit.
// Handshake: no valid/ready; WritePPI is a level sampled every CLK, read data and Hit follow AddressIO by one CLK.
interface gpio_input_port_if;
   import gpio_pkg::*;

   logic [AddrW-1:0] AddressIO;
   logic [DataW-1:0] DataOutputTowardIO;
   logic             WritePPI;
   logic [DataW-1:0] DataInputTowardMicro;
   logic             Hit;

   modport master (
      output AddressIO, DataOutputTowardIO, WritePPI,
      input  DataInputTowardMicro, Hit
   );

   modport slave (
      input  AddressIO, DataOutputTowardIO, WritePPI,
      output DataInputTowardMicro, Hit
   );

endinterface

// File: rtl/gpio_debounce_bit.sv
// One input bit: 2-flop synchroniser, tick-sampled history and debounced Stable level.
module gpio_debounce_bit #(
   parameter int DebounceSamples = 3
) (
   input  logic CLK,
   input  logic Reset,
   input  logic Pin,
   input  logic Tick,
   output logic Stable,
   output logic Change
);

   logic                       sync1;
   logic                       sync2;
   logic [DebounceSamples-1:0] hist;
   logic [DebounceSamples-1:0] histNext;
   logic                       allEqual;

   // Stable is judged on the history including this tick's sample, so a clean
   // level is accepted on the DebounceSamples-th matching tick.
   assign histNext = {hist[DebounceSamples-2:0], sync2};
   assign allEqual = (&histNext) | ~(|histNext);
   assign Change   = Tick & allEqual & (histNext[0] != Stable);

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         hist   <= '0;
         Stable <= 1'b0;
      end else begin
         sync1 <= Pin;
         sync2 <= sync1;
         if (Tick) begin
            hist <= histNext;
            if (allEqual) Stable <= histNext[0];
         end
      end
   end

endmodule

// File: rtl/gpio_input_port.sv
// Memory-mapped debounced input port with sticky any-edge flags, interrupt mask and Irq.
module gpio_input_port
   import gpio_pkg::*;
#(
   parameter int               Width           = 31,
   parameter logic [AddrW-1:0] AddrData        = DefAddrData,
   parameter logic [AddrW-1:0] AddrEdge        = DefAddrEdge,
   parameter logic [AddrW-1:0] AddrMask        = DefAddrMask,
   parameter int               DebounceDiv     = 16,
   parameter int               DebounceSamples = 3
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [Width-1:0]  DataInput_GPIO,
   gpio_input_port_if.slave  bus,
   output logic              Irq
);

   localparam int CntW = $clog2(DebounceDiv);

   logic [CntW-1:0]  tickCnt;
   logic             tick;
   logic [Width-1:0] stable;
   logic [Width-1:0] change;
   logic [Width-1:0] edgeFlag;
   logic [Width-1:0] edgeNext;
   logic [Width-1:0] mask;
   logic [Width-1:0] maskNext;
   logic [Width-1:0] readSel;
   logic             hitNext;
   logic             wrEdge;
   logic             wrMask;

   assign tick = (tickCnt == CntW'(DebounceDiv - 1));

   for (genvar i = 0; i < Width; i++) begin : g_bit
      gpio_debounce_bit #(
         .DebounceSamples(DebounceSamples)
      ) u_deb (
         .CLK   (CLK),
         .Reset (Reset),
         .Pin   (DataInput_GPIO[i]),
         .Tick  (tick),
         .Stable(stable[i]),
         .Change(change[i])
      );
   end

   assign wrEdge = bus.WritePPI && (bus.AddressIO == AddrEdge);
   assign wrMask = bus.WritePPI && (bus.AddressIO == AddrMask);

   always_comb begin
      edgeNext = edgeFlag;
      maskNext = mask;
      if (wrEdge) edgeNext = edgeFlag & ~bus.DataOutputTowardIO[Width-1:0];
      // A new edge is ORed in after the clear so a colliding W1C never loses it.
      edgeNext = edgeNext | change;
      if (wrMask) maskNext = bus.DataOutputTowardIO[Width-1:0];
   end

   always_comb begin
      readSel = '0;
      hitNext = 1'b1;
      case (bus.AddressIO)
         AddrData: readSel = stable;
         AddrEdge: readSel = edgeFlag;
         AddrMask: readSel = mask;
         default:  hitNext = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         tickCnt                  <= '0;
         edgeFlag                 <= '0;
         mask                     <= '0;
         bus.DataInputTowardMicro <= '0;
         bus.Hit                  <= 1'b0;
         Irq                      <= 1'b0;
      end else begin
         tickCnt                  <= tick ? '0 : tickCnt + 1'b1;
         edgeFlag                 <= edgeNext;
         mask                     <= maskNext;
         bus.DataInputTowardMicro <= DataW'(readSel);
         bus.Hit                  <= hitNext;
         Irq                      <= |(edgeNext & maskNext);
      end
   end

endmodule

// File: tb/tb_gpio_input_port.sv
// Self-checking bench for gpio_input_port (Width=8, DebounceDiv=4, DebounceSamples=3).
module tb_gpio_input_port;
   import gpio_pkg::*;

   localparam int W  = 8;
   localparam int DV = 4;
   localparam int NS = 3;

   logic         CLK = 1'b0;
   logic         Reset = 1'b0;
   logic [W-1:0] pins = '0;
   logic         Irq;
   int           testsRun = 0;
   int           testsFailed = 0;

   gpio_input_port_if bus ();

   gpio_input_port #(
      .Width(W), .AddrData(9'd30), .AddrEdge(9'd31), .AddrMask(9'd32),
      .DebounceDiv(DV), .DebounceSamples(NS)
   ) dut (
      .CLK(CLK), .Reset(Reset), .DataInput_GPIO(pins), .bus(bus), .Irq(Irq)
   );

   always #5 CLK = ~CLK;

   // Reference model: per-bit run length of equal tick samples; a level is accepted
   // once it has been seen on NS consecutive ticks. Sync is the pin value 2 CLK ago.
   logic [W-1:0] syncQ[$];
   int           cnt;
   logic [W-1:0] runVal;
   int           runLen[W];
   logic [W-1:0] mStable, mEdge, mMask, setv, smp;
   logic [31:0]  expRead;
   logic         expHit, expIrq, mTick;

   always @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         syncQ = {8'h00, 8'h00};
         cnt = 0;
         runVal = '0;
         for (int i = 0; i < W; i++) runLen[i] = NS;
         mStable = '0; mEdge = '0; mMask = '0;
         expRead = '0; expHit = 1'b0; expIrq = 1'b0;
      end else begin
         smp = syncQ[0];
         void'(syncQ.pop_front());
         syncQ.push_back(pins);
         mTick = (cnt == DV - 1);
         cnt = (cnt + 1) % DV;
         expHit = 1'b1;
         case (bus.AddressIO)
            9'd30:   expRead = 32'(mStable);
            9'd31:   expRead = 32'(mEdge);
            9'd32:   expRead = 32'(mMask);
            default: begin expRead = '0; expHit = 1'b0; end
         endcase
         setv = '0;
         if (mTick) begin
            for (int i = 0; i < W; i++) begin
               if (smp[i] == runVal[i]) runLen[i]++;
               else begin runVal[i] = smp[i]; runLen[i] = 1; end
               if (runLen[i] >= NS && runVal[i] != mStable[i]) begin
                  mStable[i] = runVal[i];
                  setv[i] = 1'b1;
               end
            end
         end
         if (bus.WritePPI && bus.AddressIO == 9'd31) mEdge = mEdge & ~bus.DataOutputTowardIO[W-1:0];
         mEdge = mEdge | setv;
         if (bus.WritePPI && bus.AddressIO == 9'd32) mMask = bus.DataOutputTowardIO[W-1:0];
         expIrq = |(mEdge & mMask);
      end
   end

   // True when the coming CLK edge will change Stable[b] according to the model.
   function automatic bit willFlip(int b);
      logic s;
      int   len;
      if (cnt != DV - 1) return 1'b0;
      s   = syncQ[0][b];
      len = (s == runVal[b]) ? runLen[b] + 1 : 1;
      return (len >= NS) && (s != mStable[b]);
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic busWrite(input logic [8:0] a, input logic [31:0] d);
      bus.AddressIO = a;
      bus.DataOutputTowardIO = d;
      bus.WritePPI = 1'b1;
      step();
      bus.WritePPI = 1'b0;
   endtask

   task automatic busRead(input logic [8:0] a);
      bus.AddressIO = a;
      step();
   endtask

   task automatic test_reset();
      bit seen;
      Reset = 1'b0;
      pins = 8'hFF;
      bus.AddressIO = 9'd30;
      repeat (5) step();
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'h0) begin
         testsFailed++;
         $display("FAIL reset_data got=%h exp=%h", bus.DataInputTowardMicro, 32'h0);
      end
      testsRun++;
      if (bus.Hit !== 1'b0) begin
         testsFailed++;
         $display("FAIL reset_hit got=%b exp=0", bus.Hit);
      end
      testsRun++;
      if (Irq !== 1'b0) begin
         testsFailed++;
         $display("FAIL reset_irq got=%b exp=0", Irq);
      end
      Reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 2 + DV * NS + 2 && !seen; i++) begin
         step();
         if (bus.DataInputTowardMicro === 32'hFF) seen = 1'b1;
      end
      testsRun++;
      if (!seen) begin
         testsFailed++;
         $display("FAIL reset_release_data got=%h exp=%h", bus.DataInputTowardMicro, 32'hFF);
      end
      busRead(9'd31);
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'hFF || bus.Hit !== 1'b1) begin
         testsFailed++;
         $display("FAIL reset_edge_read got=%h hit=%b exp=%h hit=1", bus.DataInputTowardMicro, bus.Hit, 32'hFF);
      end
      pins = 8'h00;
      repeat (20) step();
      busWrite(9'd31, 32'hFF);
   endtask

   task automatic test_glitch();
      busRead(9'd30);
      pins[0] = 1'b1;
      repeat (5) step();
      pins[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         testsRun++;
         if (bus.DataInputTowardMicro !== 32'h0) begin
            testsFailed++;
            $display("FAIL glitch_data cyc=%0d got=%h exp=%h", i, bus.DataInputTowardMicro, 32'h0);
         end
      end
      busRead(9'd31);
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'h0) begin
         testsFailed++;
         $display("FAIL glitch_edge got=%h exp=%h", bus.DataInputTowardMicro, 32'h0);
      end
   endtask

   task automatic test_w1c();
      pins = 8'h0F;
      repeat (20) step();
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'h0F) begin
         testsFailed++;
         $display("FAIL w1c_setup got=%h exp=%h", bus.DataInputTowardMicro, 32'h0F);
      end
      busWrite(9'd31, 32'h05);
      busRead(9'd31);
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'h0A) begin
         testsFailed++;
         $display("FAIL w1c_clear got=%h exp=%h", bus.DataInputTowardMicro, 32'h0A);
      end
      busWrite(9'd30, 32'hFFFF_FFFF);
      busRead(9'd30);
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'h0F) begin
         testsFailed++;
         $display("FAIL w1c_data_ro got=%h exp=%h", bus.DataInputTowardMicro, 32'h0F);
      end
   endtask

   task automatic test_collision();
      bit found;
      bus.AddressIO = 9'd31;
      pins[2] = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (willFlip(2)) found = 1'b1;
         else step();
      end
      testsRun++;
      if (!found) begin
         testsFailed++;
         $display("FAIL collision_timeout got=none exp=stable2_toggle");
      end
      busWrite(9'd31, 32'h04);
      busRead(9'd31);
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'h0E) begin
         testsFailed++;
         $display("FAIL collision_edge got=%h exp=%h", bus.DataInputTowardMicro, 32'h0E);
      end
   endtask

   task automatic test_irq();
      bit rose;
      busWrite(9'd31, 32'hFF);
      busWrite(9'd32, 32'h10);
      busRead(9'd32);
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'h10) begin
         testsFailed++;
         $display("FAIL irq_mask_read got=%h exp=%h", bus.DataInputTowardMicro, 32'h10);
      end
      pins[4] = 1'b1;
      rose = 1'b0;
      for (int i = 0; i < 40 && !rose; i++) begin
         step();
         testsRun++;
         if (Irq !== expIrq) begin
            testsFailed++;
            $display("FAIL irq_rise cyc=%0d got=%b exp=%b", i, Irq, expIrq);
         end
         if (expIrq) rose = 1'b1;
      end
      testsRun++;
      if (Irq !== 1'b1) begin
         testsFailed++;
         $display("FAIL irq_high got=%b exp=1", Irq);
      end
      busWrite(9'd31, 32'h10);
      testsRun++;
      if (Irq !== 1'b0) begin
         testsFailed++;
         $display("FAIL irq_clear got=%b exp=0", Irq);
      end
      pins[3] = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         testsRun++;
         if (Irq !== 1'b0) begin
            testsFailed++;
            $display("FAIL irq_masked cyc=%0d got=%b exp=0", i, Irq);
         end
      end
      busRead(9'd31);
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'h08) begin
         testsFailed++;
         $display("FAIL irq_masked_edge got=%h exp=%h", bus.DataInputTowardMicro, 32'h08);
      end
   endtask

   task automatic test_decode();
      busWrite(9'd33, 32'hFFFF_FFFF);
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'h0 || bus.Hit !== 1'b0) begin
         testsFailed++;
         $display("FAIL decode_miss got=%h hit=%b exp=%h hit=0", bus.DataInputTowardMicro, bus.Hit, 32'h0);
      end
      busRead(9'd32);
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'h10 || bus.Hit !== 1'b1) begin
         testsFailed++;
         $display("FAIL decode_mask got=%h hit=%b exp=%h hit=1", bus.DataInputTowardMicro, bus.Hit, 32'h10);
      end
      busRead(9'd31);
      testsRun++;
      if (bus.DataInputTowardMicro !== 32'h08) begin
         testsFailed++;
         $display("FAIL decode_edge got=%h exp=%h", bus.DataInputTowardMicro, 32'h08);
      end
   endtask

   task automatic test_random();
      int hold;
      logic [8:0] addrs[5];
      addrs = '{9'd30, 9'd31, 9'd32, 9'd33, 9'd0};
      hold = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold == 0) begin
            pins = W'($urandom);
            hold = $urandom_range(1, 20);
         end
         hold--;
         bus.AddressIO = addrs[$urandom_range(0, 4)];
         bus.DataOutputTowardIO = $urandom;
         bus.WritePPI = ($urandom_range(0, 3) == 0);
         step();
         testsRun++;
         if (bus.DataInputTowardMicro !== expRead || bus.Hit !== expHit || Irq !== expIrq) begin
            testsFailed++;
            $display("FAIL random cyc=%0d got=%h/%b/%b exp=%h/%b/%b", i,
                     bus.DataInputTowardMicro, bus.Hit, Irq, expRead, expHit, expIrq);
         end
      end
      bus.WritePPI = 1'b0;
   endtask

   initial begin
      bus.AddressIO = '0;
      bus.DataOutputTowardIO = '0;
      bus.WritePPI = 1'b0;
      test_reset();
      test_glitch();
      test_w1c();
      test_collision();
      test_irq();
      test_decode();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
